// File: rtl/pw_pkg.sv
// Shared definitions for the login stage: FSM states, sizes and the per-player password table.
package pw_pkg;

    localparam int PW_DIGITS = 6;
    localparam int ADDR_W    = 5;
    localparam int PW_W      = 4 * PW_DIGITS;
    localparam int CNT_W     = 3;
    localparam int N_PLAYERS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_CHECK,
        S_LOGGED_IN,
        S_LOGOUT
    } state_t;

    // Unlisted players fall back to an all-zero password.
    localparam logic [PW_W-1:0] PW_TABLE [N_PLAYERS] = '{
        1:       24'hDA5A55,
        default: 24'h000000
    };

endpackage

// File: rtl/password_rom.sv
// Combinational player-address to stored-password lookup.
module password_rom
    import pw_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output logic [PW_W-1:0]   o_pw
);

    assign o_pw = PW_TABLE[i_addr];

endmodule

// File: rtl/password_handler.sv
// Login stage: collects a hex password digit by digit, verifies it against the ROM,
// and holds the session until the game controller requests logout.
module password_handler
    import pw_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        Switches,
    input  logic              PasswordButton,
    input  logic              MatchedID,
    input  logic [ADDR_W-1:0] PlayerAddress_from_ID,
    input  logic              LogoutCommand_from_GC,
    input  logic              isGuest_from_ID,
    output logic              LoggedOut,
    output logic              LoggedIn,
    output logic              isGuest_to_GC,
    output logic              Logout_to_ID,
    output logic [ADDR_W-1:0] PlayerAddress_to_GC
);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PW_W-1:0]    r_shreg, w_shreg_nxt;
    logic               r_chk_armed, w_chk_armed_nxt;
    logic               r_match, w_match_nxt;
    logic               r_logged_in, w_logged_in_nxt;
    logic               r_logged_out, w_logged_out_nxt;
    logic               r_guest, w_guest_nxt;
    logic               r_logout, w_logout_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [PW_W-1:0]    w_rom_pw;

    password_rom u_rom (
        .i_addr (PlayerAddress_from_ID),
        .o_pw   (w_rom_pw)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_chk_armed  <= 1'b0;
            r_match      <= 1'b0;
            r_logged_in  <= 1'b0;
            r_logged_out <= 1'b1;
            r_guest      <= 1'b0;
            r_logout     <= 1'b0;
            r_addr       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_chk_armed  <= w_chk_armed_nxt;
            r_match      <= w_match_nxt;
            r_logged_in  <= w_logged_in_nxt;
            r_logged_out <= w_logged_out_nxt;
            r_guest      <= w_guest_nxt;
            r_logout     <= w_logout_nxt;
            r_addr       <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shreg_nxt      = r_shreg;
        w_chk_armed_nxt  = r_chk_armed;
        w_match_nxt      = r_match;
        w_logged_in_nxt  = r_logged_in;
        w_logged_out_nxt = r_logged_out;
        w_guest_nxt      = r_guest;
        w_addr_nxt       = r_addr;
        w_logout_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (MatchedID) begin
                    if (isGuest_from_ID) begin
                        w_state_nxt      = S_LOGGED_IN;
                        w_logged_in_nxt  = 1'b1;
                        w_logged_out_nxt = 1'b0;
                        w_guest_nxt      = 1'b1;
                        w_addr_nxt       = PlayerAddress_from_ID;
                    end else begin
                        w_state_nxt = S_ENTER;
                        w_cnt_nxt   = '0;
                        w_shreg_nxt = '0;
                    end
                end
            end

            S_ENTER: begin
                if (!MatchedID) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                end else if (PasswordButton) begin
                    w_shreg_nxt = {r_shreg[PW_W-5:0], Switches};
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(PW_DIGITS - 1)) begin
                        w_state_nxt     = S_CHECK;
                        w_chk_armed_nxt = 1'b0;
                    end
                end
            end

            // First CHECK cycle registers the comparison; the second acts on it.
            S_CHECK: begin
                if (!MatchedID) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                end else if (!r_chk_armed) begin
                    w_chk_armed_nxt = 1'b1;
                    w_match_nxt     = (r_shreg == w_rom_pw);
                end else if (r_match) begin
                    w_state_nxt      = S_LOGGED_IN;
                    w_logged_in_nxt  = 1'b1;
                    w_logged_out_nxt = 1'b0;
                    w_guest_nxt      = 1'b0;
                    w_addr_nxt       = PlayerAddress_from_ID;
                end else begin
                    w_state_nxt = S_ENTER;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                end
            end

            S_LOGGED_IN: begin
                if (LogoutCommand_from_GC) begin
                    w_state_nxt      = S_LOGOUT;
                    w_logged_in_nxt  = 1'b0;
                    w_logged_out_nxt = 1'b1;
                    w_guest_nxt      = 1'b0;
                    w_addr_nxt       = '0;
                    w_logout_nxt     = 1'b1;
                end
            end

            // Hold here until the ID handler drops its stale match.
            S_LOGOUT: begin
                if (!MatchedID) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign LoggedIn            = r_logged_in;
    assign LoggedOut           = r_logged_out;
    assign isGuest_to_GC       = r_guest;
    assign Logout_to_ID        = r_logout;
    assign PlayerAddress_to_GC = r_addr;

endmodule

// File: tb/tb_password_handler.sv
// Directed bench for password_handler with an event-level login model and literal spot checks.
module tb_password_handler;

    logic       clk;
    logic       rst;
    logic [3:0] Switches;
    logic       PasswordButton;
    logic       MatchedID;
    logic [4:0] PlayerAddress_from_ID;
    logic       LogoutCommand_from_GC;
    logic       isGuest_from_ID;
    logic       LoggedOut;
    logic       LoggedIn;
    logic       isGuest_to_GC;
    logic       Logout_to_ID;
    logic [4:0] PlayerAddress_to_GC;

    int total = 0;
    int bad   = 0;

    password_handler dut (
        .clk                   (clk),
        .rst                   (rst),
        .Switches              (Switches),
        .PasswordButton        (PasswordButton),
        .MatchedID             (MatchedID),
        .PlayerAddress_from_ID (PlayerAddress_from_ID),
        .LogoutCommand_from_GC (LogoutCommand_from_GC),
        .isGuest_from_ID       (isGuest_from_ID),
        .LoggedOut             (LoggedOut),
        .LoggedIn              (LoggedIn),
        .isGuest_to_GC         (isGuest_to_GC),
        .Logout_to_ID          (Logout_to_ID),
        .PlayerAddress_to_GC   (PlayerAddress_to_GC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Login model: digits are kept as a list and folded into a number only at verdict time.
    function automatic int stored_pw(input int a);
        return (a == 1) ? 32'hDA5A55 : 0;
    endfunction

    int  m_digits[$];
    bit  m_valid, m_session, m_guest, m_pulse, m_wait_drop, m_entering;
    int  m_addr, m_pending;

    initial begin
        logic       c_rst, c_btn, c_match, c_lo, c_gst;
        logic [3:0] c_sw;
        logic [4:0] c_pa;
        int         pw;
        m_valid = 0; m_session = 0; m_guest = 0; m_pulse = 0;
        m_wait_drop = 0; m_entering = 0; m_addr = 0; m_pending = 0;
        forever begin
            @(posedge clk);
            c_rst = rst; c_btn = PasswordButton; c_match = MatchedID; c_lo = LogoutCommand_from_GC;
            c_gst = isGuest_from_ID; c_sw = Switches; c_pa = PlayerAddress_from_ID;
            @(negedge clk);
            m_pulse = 0;
            if (!c_rst) begin
                m_valid = 1; m_session = 0; m_guest = 0; m_addr = 0;
                m_wait_drop = 0; m_entering = 0; m_pending = 0; m_digits.delete();
            end else if (m_session) begin
                if (c_lo) begin
                    m_session = 0; m_guest = 0; m_addr = 0; m_pulse = 1; m_wait_drop = 1;
                end
            end else if (m_wait_drop) begin
                if (!c_match) m_wait_drop = 0;
            end else if (!c_match) begin
                m_entering = 0; m_pending = 0; m_digits.delete();
            end else if (!m_entering) begin
                if (c_gst) begin
                    m_session = 1; m_guest = 1; m_addr = int'(c_pa);
                end else begin
                    m_entering = 1; m_digits.delete();
                end
            end else if (m_pending > 0) begin
                m_pending--;
                if (m_pending == 0) begin
                    pw = 0;
                    foreach (m_digits[i]) pw = pw * 16 + m_digits[i];
                    if (pw == stored_pw(int'(c_pa))) begin
                        m_session = 1; m_guest = 0; m_addr = int'(c_pa); m_entering = 0;
                    end
                    m_digits.delete();
                end
            end else if (c_btn === 1'b1) begin
                m_digits.push_back(int'(c_sw));
                if (m_digits.size() == 6) m_pending = 2;
            end
            if (m_valid) begin
                check("model_LoggedIn", int'(LoggedIn), int'(m_session));
                check("model_LoggedOut", int'(LoggedOut), int'(!m_session));
                check("model_isGuest", int'(isGuest_to_GC), int'(m_guest));
                check("model_addr", int'(PlayerAddress_to_GC), m_addr);
                check("model_Logout_to_ID", int'(Logout_to_ID), int'(m_pulse));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        Switches = d;
        PasswordButton = 1'b1;
        @(negedge clk);
        PasswordButton = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter6(input logic [23:0] pw);
        for (int i = 5; i >= 0; i--) press(pw[i*4 +: 4]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pw_wrong, pw_good;
        pw_wrong = 24'h037446;
        pw_good  = 24'hDA5A55;
        rst = 1'b0; Switches = 4'h0; PasswordButton = 1'b0; MatchedID = 1'b0;
        PlayerAddress_from_ID = 5'd0; LogoutCommand_from_GC = 1'b0; isGuest_from_ID = 1'b0;

        // Reset
        tick(2); #1;
        check("rst_LoggedOut", int'(LoggedOut), 1);
        check("rst_LoggedIn", int'(LoggedIn), 0);
        check("rst_addr", int'(PlayerAddress_to_GC), 0);
        check("rst_Logout_to_ID", int'(Logout_to_ID), 0);
        rst = 1'b1;
        tick(3); #1;
        check("idle_LoggedOut", int'(LoggedOut), 1);

        // Wrong password, then correct one with exact latency
        MatchedID = 1'b1; PlayerAddress_from_ID = 5'd1; isGuest_from_ID = 1'b0;
        tick(1);
        enter6(pw_wrong);
        tick(2); #1;
        check("wrong_LoggedIn", int'(LoggedIn), 0);
        for (int i = 5; i >= 1; i--) press(pw_good[i*4 +: 4]);
        @(negedge clk);
        Switches = pw_good[3:0];
        PasswordButton = 1'b1;
        @(negedge clk);
        PasswordButton = 1'b0;
        #1 check("lat_edge0_LoggedIn", int'(LoggedIn), 0);
        @(negedge clk); #1;
        check("lat_edge1_LoggedIn", int'(LoggedIn), 0);
        @(negedge clk); #1;
        check("lat_edge2_LoggedIn", int'(LoggedIn), 1);
        check("good_LoggedOut", int'(LoggedOut), 0);
        check("good_addr", int'(PlayerAddress_to_GC), 1);
        check("good_isGuest", int'(isGuest_to_GC), 0);

        // Logout with stale match
        tick(2);
        LogoutCommand_from_GC = 1'b1;
        @(negedge clk); #1;
        check("logout_pulse", int'(Logout_to_ID), 1);
        check("logout_LoggedOut", int'(LoggedOut), 1);
        check("logout_addr", int'(PlayerAddress_to_GC), 0);
        @(negedge clk);
        LogoutCommand_from_GC = 1'b0;
        #1 check("logout_pulse_end", int'(Logout_to_ID), 0);
        @(negedge clk);
        MatchedID = 1'b0;
        #1 check("stale_no_relogin", int'(LoggedIn), 0);
        tick(3);

        // Guest
        MatchedID = 1'b1; PlayerAddress_from_ID = 5'd4; isGuest_from_ID = 1'b1;
        tick(2); #1;
        check("guest_LoggedIn", int'(LoggedIn), 1);
        check("guest_addr", int'(PlayerAddress_to_GC), 4);
        check("guest_isGuest", int'(isGuest_to_GC), 1);
        LogoutCommand_from_GC = 1'b1;
        tick(1);
        LogoutCommand_from_GC = 1'b0;
        MatchedID = 1'b0; isGuest_from_ID = 1'b0;
        tick(3);

        // Abort after 3 digits; logout request ignored while entering
        MatchedID = 1'b1; PlayerAddress_from_ID = 5'd1;
        tick(1);
        press(4'hD); press(4'hA);
        LogoutCommand_from_GC = 1'b1;
        press(4'h5);
        LogoutCommand_from_GC = 1'b0;
        MatchedID = 1'b0;
        tick(2);
        MatchedID = 1'b1;
        tick(1);
        press(4'hA); press(4'h5); press(4'h5);
        tick(3); #1;
        check("abort_partial_LoggedIn", int'(LoggedIn), 0);
        press(4'h0); press(4'h0); press(4'h0);
        tick(3); #1;
        check("abort_wrong_LoggedIn", int'(LoggedIn), 0);
        enter6(pw_good);
        tick(2); #1;
        check("abort_full_LoggedIn", int'(LoggedIn), 1);
        check("abort_full_addr", int'(PlayerAddress_to_GC), 1);

        // Reset mid-session: no logout pulse
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("midrst_LoggedIn", int'(LoggedIn), 0);
        check("midrst_pulse", int'(Logout_to_ID), 0);
        rst = 1'b1; MatchedID = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
